// File: rtl/avg_pool_unit.sv
// avg_pool_unit -- non-overlapping window average of a signed sample stream.
//
// Accumulates WINDOW accepted samples and publishes their mean (floor
// division, via arithmetic shift) on the edge that accepts the last one.
// Samples may arrive with arbitrary idle gaps; windows may run back-to-back.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   enable  : sample-accept qualifier
//   layer2  : signed sample, DATA_W bits
//   avg     : registered mean of the last completed window, held until the next
//   valid   : registered one-cycle pulse per completed window
module avg_pool_unit #(
  parameter int DATA_W = 32,
  parameter int WINDOW = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] layer2,
  output logic signed [DATA_W-1:0] avg,
  output logic                     valid
);

  localparam int SH    = $clog2(WINDOW);
  localparam int ACC_W = DATA_W + SH;

  generate
    if (WINDOW < 2 || WINDOW > 16 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
      $error("avg_pool_unit: WINDOW must be a power of two in 2..16");
    end
  endgenerate

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic        [SH-1:0]    cnt;
  logic                    last;

  // SH guard bits on top of DATA_W make the sum of WINDOW samples overflow-free.
  assign acc_nxt = acc + {{SH{layer2[DATA_W-1]}}, layer2};
  assign last    = (cnt == SH'(WINDOW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      avg   <= '0;
      valid <= 1'b0;
    end else begin
      // valid is a pulse: it drops on every edge that does not complete a window.
      valid <= 1'b0;
      if (enable) begin
        if (last) begin
          // Dropping the low SH bits of the signed sum is an arithmetic shift
          // right (floor toward -inf); the mean always fits DATA_W bits.
          avg   <= acc_nxt[ACC_W-1:SH];
          valid <= 1'b1;
          acc   <= '0;
          cnt   <= '0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_avg_pool_unit.sv
module tb_avg_pool_unit;

  localparam int DATA_W = 32;
  localparam int WINDOW = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     enable = 1'b0;
  logic signed [DATA_W-1:0] layer2 = '0;
  logic signed [DATA_W-1:0] avg;
  logic                     valid;

  int n_cmp = 0;
  int n_err = 0;

  avg_pool_unit #(.DATA_W(DATA_W), .WINDOW(WINDOW)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .layer2 (layer2),
    .avg    (avg),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                     r;
    logic                     en;
    logic signed [DATA_W-1:0] d;
    logic                     exp_valid;
    logic signed [DATA_W-1:0] exp_avg;
    string                    tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic en, input logic signed [DATA_W-1:0] d,
                              input logic ev, input logic signed [DATA_W-1:0] ea, input string tag);
    vec_t v;
    v.r = r; v.en = en; v.d = d; v.exp_valid = ev; v.exp_avg = ea; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic signed [DATA_W-1:0] got,
                     input logic signed [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, got, got, exp, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after
  // the following rising edge.
  task automatic drive(input logic r, input logic en, input logic signed [DATA_W-1:0] d);
    @(negedge clk);
    rst = r; enable = en; layer2 = d;
    @(posedge clk);
    #1;
  endtask

  localparam logic signed [DATA_W-1:0] MAXP = 32'sh7FFF_FFFF;
  localparam logic signed [DATA_W-1:0] MINN = 32'sh8000_0000;

  initial begin : main
    int pulses;

    // reset state
    add(1, 0, 0,   0, 0,  "reset");
    // 10,20,30,40 -> 25, held after enable drops
    add(0, 1, 10,  0, 0,  "w1_s1");
    add(0, 1, 20,  0, 0,  "w1_s2");
    add(0, 1, 30,  0, 0,  "w1_s3");
    add(0, 1, 40,  1, 25, "w1_done");
    add(0, 0, 0,   0, 25, "w1_hold1");
    add(0, 0, 99,  0, 25, "w1_hold2");
    // -1..-4 -> floor(-2.5) = -3
    add(0, 1, -1,  0, 25, "neg_s1");
    add(0, 1, -2,  0, 25, "neg_s2");
    add(0, 1, -3,  0, 25, "neg_s3");
    add(0, 1, -4,  1, -3, "neg_done");
    // 1,2,3,5 -> floor(2.75) = 2, back-to-back with previous window
    add(0, 1, 1,   0, -3, "pos_s1");
    add(0, 1, 2,   0, -3, "pos_s2");
    add(0, 1, 3,   0, -3, "pos_s3");
    add(0, 1, 5,   1, 2,  "pos_done");
    // extremes
    add(0, 1, MAXP, 0, 2,    "max_s1");
    add(0, 1, MAXP, 0, 2,    "max_s2");
    add(0, 1, MAXP, 0, 2,    "max_s3");
    add(0, 1, MAXP, 1, MAXP, "max_done");
    add(0, 1, MINN, 0, MAXP, "min_s1");
    add(0, 1, MINN, 0, MAXP, "min_s2");
    add(0, 1, MINN, 0, MAXP, "min_s3");
    add(0, 1, MINN, 1, MINN, "min_done");
    // window spanning idle cycles
    add(0, 1, 8,   0, MINN, "gap_s1");
    add(0, 1, 8,   0, MINN, "gap_s2");
    add(0, 0, 77,  0, MINN, "gap_idle1");
    add(0, 0, 77,  0, MINN, "gap_idle2");
    add(0, 0, 77,  0, MINN, "gap_idle3");
    add(0, 1, 8,   0, MINN, "gap_s3");
    add(0, 1, 8,   1, 8,    "gap_done");
    add(0, 0, 0,   0, 8,    "gap_after");
    // reset mid-window, rst+enable together drops the sample
    add(0, 1, 100, 0, 8,  "rst_pre1");
    add(0, 1, 100, 0, 8,  "rst_pre2");
    add(1, 1, 100, 0, 0,  "rst_with_en");
    add(1, 0, 0,   0, 0,  "rst_hold");
    add(0, 1, 4,   0, 0,  "rst_s1");
    add(0, 1, 4,   0, 0,  "rst_s2");
    add(0, 1, 4,   0, 0,  "rst_s3");
    add(0, 1, 4,   1, 4,  "rst_done");
    // 1..8 back to back -> 2 then 6
    add(0, 1, 1,   0, 4,  "seq_s1");
    add(0, 1, 2,   0, 4,  "seq_s2");
    add(0, 1, 3,   0, 4,  "seq_s3");
    add(0, 1, 4,   1, 2,  "seq_s4");
    add(0, 1, 5,   0, 2,  "seq_s5");
    add(0, 1, 6,   0, 2,  "seq_s6");
    add(0, 1, 7,   0, 2,  "seq_s7");
    add(0, 1, 8,   1, 6,  "seq_s8");
    add(0, 0, 0,   0, 6,  "seq_idle");

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].en, vecs[i].d);
      chk({vecs[i].tag, ".avg"}, avg, vecs[i].exp_avg);
      chk({vecs[i].tag, ".valid"}, {{(DATA_W-1){1'b0}}, valid}, {{(DATA_W-1){1'b0}}, vecs[i].exp_valid});
    end

    // Asynchronous reset between clock edges clears avg immediately.
    drive(0, 1, 50);
    drive(0, 1, 50);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.avg", avg, 0);
    chk("async_rst.valid", {{(DATA_W-1){1'b0}}, valid}, 0);
    drive(0, 0, 0);
    chk("async_rst.after", avg, 0);
    // The partial 50,50 must not leak into the next window: 2,2,2,2 -> 2.
    drive(0, 1, 2);
    drive(0, 1, 2);
    drive(0, 1, 2);
    chk("async_rst.partial", {{(DATA_W-1){1'b0}}, valid}, 0);
    drive(0, 1, 2);
    chk("async_rst.win_valid", {{(DATA_W-1){1'b0}}, valid}, 1);
    chk("async_rst.win_avg", avg, 2);

    // Three back-to-back windows of 0..11: exactly three pulses, last = floor(9.5).
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, k);
      if (valid) pulses++;
    end
    drive(0, 0, 0);
    if (valid) pulses++;
    chk("b2b.pulses", pulses, 3);
    chk("b2b.avg", avg, 9);

    // Bounded wait: a two-sample partial window must never produce a pulse.
    drive(0, 1, 1000);
    drive(0, 1, 1000);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0);
      if (valid) pulses++;
    end
    chk("partial.no_pulse", pulses, 0);
    chk("partial.avg_held", avg, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
